hv_owt_tx_ctrl: RTL
===================

Name: hv_owt_tx_ctrl

Overview:
- Transmitter end of the one-wire (OWT) link. Serialises one command/data frame onto the single wire, and the LV-side OWT receiver decodes it.
- Frame order: Manchester sync head, raw sync tail, command, normal or ADC data, CRC8, raw data tail.
- Sits between the HV register/ADC response logic (requester) and the HV-to-LV isolator pad.

Parameters:
- OWT_EXT_CYC_NUM, 4, clocks per half-bit (line level held this long)
- OWT_SYNC_BIT_NUM, 12, Manchester zeros in the sync head
- OWT_TAIL_BIT_NUM, 4, raw half-bit levels in each tail
- OWT_CMD_BIT_NUM, 8, command bits; MSB=1 write, MSB=0 read
- OWT_DBIT_NUM, 8, normal data bits
- OWT_ADC_DBIT_NUM, 10, ADC data bits (must be >= OWT_DBIT_NUM)
- OWT_CRC_BIT_NUM, 8, CRC bits

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_owt_tx_req  in  1  frame request, level; sampled only in IDLE
- i_owt_tx_cmd  in  OWT_CMD_BIT_NUM  command, latched on accept
- i_owt_tx_data  in  OWT_ADC_DBIT_NUM  data, latched on accept; normal frames use bits [OWT_DBIT_NUM-1:0]
- o_owt_tx_ack  out  1  one-cycle pulse: request accepted
- o_owt_tx_done  out  1  one-cycle pulse: frame fully sent
- o_owt_tx_busy  out  1  high from the cycle after accept until done
- o_hv_lv_owt_tx  out  1  line output, registered, idle high

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - o_hv_lv_owt_tx=1; ack, done and busy =0; FSM returns to IDLE.
  - Latched cmd/data, counters and CRC cleared.
  - No partial frame is resumed after reset.
- Manchester encoding, MSB first:
  - bit 0 = half-bit high then half-bit low (falling mid-bit edge);
  - bit 1 = half-bit low then half-bit high.
- Raw tail levels are sent as plain half-bits, pattern 1,1,0,0.
- FSM states: IDLE, SYNC_HEAD, SYNC_TAIL, CMD, ADC_DATA, NML_DATA, CRC, VLD_DATA_TAIL.
- Transitions:
  - IDLE -> SYNC_HEAD when i_owt_tx_req=1. In that cycle: ack=1, cmd/data latched, CRC cleared.
  - SYNC_HEAD -> SYNC_TAIL after OWT_SYNC_BIT_NUM zero bits.
  - SYNC_TAIL -> CMD after 4 raw half-bits.
  - CMD -> ADC_DATA if cmd MSB=0 and cmd[6:0]==7'h1F; otherwise CMD -> NML_DATA.
  - ADC_DATA or NML_DATA -> CRC after the data bits.
  - CRC -> VLD_DATA_TAIL after 8 bits.
  - VLD_DATA_TAIL -> IDLE after 4 raw half-bits.
- Timing:
  - The first line half-bit starts the cycle after accept.
  - Every half-bit lasts exactly OWT_EXT_CYC_NUM clocks.
  - Half-bit counter wraps at OWT_EXT_CYC_NUM-1; bit counter resets on every state change.
- Frame length:
  - Normal frame: 2*12+4+2*(8+8+8)+4 = 80 half-bits.
  - ADC frame: 84 half-bits.
- CRC8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Computed serially over the command bits then the data bits, in transmit order.
  - Advanced once per data bit at bit start; value frozen on entry to CRC.
- End of frame:
  - The cycle after the final tail half-bit: FSM is in IDLE, line=1, done=1, busy=0.
  - A new request may be accepted in that same cycle, so ack and done can be simultaneous.
- Requests while busy are ignored, with no queueing; the requester holds req until it sees ack.
- Changes on i_owt_tx_cmd or i_owt_tx_data after accept have no effect on the frame in flight.

Optional Feature:
- Macro: HV_OWT_TX_CRC_ERR_INJ_EN.
- When defined:
  - Adds input port i_owt_tx_crc_inj (1 bit), latched on accept.
  - If set, the transmitted CRC field is the bitwise inverse of the computed CRC. The receiver must then report error status.
- When undefined: the port is absent and the CRC is always transmitted true.

Decomposition:
- Shared lv/hv parameter include holds:
  - FSM state encodings (OWT_*_ST) and OWT_FSM_ST_W, common with the receiver;
  - all bit-count constants;
  - tail pattern 4'b1100;
  - ADC-read command code 7'h1F.
- Sub-module: reuse crc8_serial, the same instance type as the receiver, so both ends match by construction.
- The Manchester half-bit generator stays inline.

Test Plan:
- Write frame: OWT_EXT_CYC_NUM=4, cmd=0x85, data=0x03C.
  - Ack at accept; line busy 320 clocks; done 321 clocks after accept.
  - A loopback receiver decodes cmd 0x85 and data 0x3C with status 0.
- ADC read: cmd=0x1F, data=0x2A5.
  - 84 half-bits (336 clocks).
  - Receiver takes the ADC path and decodes 0x2A5; CRC matches the reference model.
- Back-to-back: req held high across two frames (cmd 0x01 then 0x02).
  - Second ack coincides with the first done; no idle gap.
  - Both frames decode correctly.
- Req pulse while busy: one-cycle req mid-frame.
  - No ack; current frame unaffected.
- Reset mid-CMD: assert i_rst_n=0 during CMD.
  - Line goes high asynchronously; busy=0 immediately.
  - After release, a new request sends a clean frame.
- With HV_OWT_TX_CRC_ERR_INJ_EN defined, cmd=0x85, data=0x03C, inj=1.
  - CRC field equals ~CRC; receiver flags error status.

Source files
------------

// File: rtl/hv_owt_tx_ctrl_pkg.sv
// ============================================================================
// Module  : hv_owt_tx_ctrl_pkg
// Brief   : Shared OWT link constants and FSM encodings (common to tx and rx).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hv_owt_tx_ctrl_pkg;

    localparam int OWT_EXT_CYC_NUM  = 4;
    localparam int OWT_SYNC_BIT_NUM = 12;
    localparam int OWT_TAIL_BIT_NUM = 4;
    localparam int OWT_CMD_BIT_NUM  = 8;
    localparam int OWT_DBIT_NUM     = 8;
    localparam int OWT_ADC_DBIT_NUM = 10;
    localparam int OWT_CRC_BIT_NUM  = 8;

    localparam int OWT_FSM_ST_W = 3;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_IDLE_ST          = 3'd0;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_SYNC_HEAD_ST     = 3'd1;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_SYNC_TAIL_ST     = 3'd2;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_CMD_ST           = 3'd3;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_ADC_DATA_ST      = 3'd4;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_NML_DATA_ST      = 3'd5;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_CRC_ST           = 3'd6;
    localparam logic [OWT_FSM_ST_W-1:0] OWT_VLD_DATA_TAIL_ST = 3'd7;

    localparam logic [OWT_TAIL_BIT_NUM-1:0] OWT_TAIL_PAT   = 4'b1100;
    localparam logic [6:0]                  OWT_ADC_RD_CMD = 7'h1F;
    localparam logic [OWT_CRC_BIT_NUM-1:0]  OWT_CRC8_POLY  = 8'h07;

endpackage

`default_nettype wire

// File: rtl/hv_owt_tx_ctrl_crc8_serial.sv
// ============================================================================
// Module  : crc8_serial
// Brief   : Bit-serial CRC8 (poly 0x07, init 0, MSB first), shared by tx/rx.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_serial
    import hv_owt_tx_ctrl_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic                       din_i,
    output logic [OWT_CRC_BIT_NUM-1:0] crc_o
);

    logic [OWT_CRC_BIT_NUM-1:0] crc_q;
    logic [OWT_CRC_BIT_NUM-1:0] crc_d;
    logic                       w_fb;

    assign w_fb = crc_q[OWT_CRC_BIT_NUM-1] ^ din_i;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[OWT_CRC_BIT_NUM-2:0], 1'b0} ^ ({OWT_CRC_BIT_NUM{w_fb}} & OWT_CRC8_POLY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/hv_owt_tx_ctrl.sv
// ============================================================================
// Module  : hv_owt_tx_ctrl
// Brief   : OWT transmitter - serialises sync/cmd/data/CRC frames onto one wire.
//           Optional macro HV_OWT_TX_CRC_ERR_INJ_EN adds CRC error injection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hv_owt_tx_ctrl
    import hv_owt_tx_ctrl_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_owt_tx_req,
    input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
    input  logic [OWT_ADC_DBIT_NUM-1:0] i_owt_tx_data,
`ifdef HV_OWT_TX_CRC_ERR_INJ_EN
    input  logic                        i_owt_tx_crc_inj,
`endif
    output logic                        o_owt_tx_ack,
    output logic                        o_owt_tx_done,
    output logic                        o_owt_tx_busy,
    output logic                        o_hv_lv_owt_tx
);

    localparam int CYC_W = (OWT_EXT_CYC_NUM > 1) ? $clog2(OWT_EXT_CYC_NUM) : 1;
    localparam int BIT_MAX_A = (OWT_SYNC_BIT_NUM > OWT_ADC_DBIT_NUM) ? OWT_SYNC_BIT_NUM : OWT_ADC_DBIT_NUM;
    localparam int BIT_MAX_B = (OWT_CMD_BIT_NUM > OWT_CRC_BIT_NUM) ? OWT_CMD_BIT_NUM : OWT_CRC_BIT_NUM;
    localparam int BIT_MAX   = (BIT_MAX_A > BIT_MAX_B) ? BIT_MAX_A : BIT_MAX_B;
    localparam int BIT_W     = $clog2(BIT_MAX + 1);
    localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(OWT_EXT_CYC_NUM - 1);

    logic [OWT_FSM_ST_W-1:0]     state_q, state_d;
    logic [CYC_W-1:0]            cyc_q, cyc_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic                        half_q, half_d;
    logic [OWT_CMD_BIT_NUM-1:0]  cmd_q, cmd_d;
    logic [OWT_ADC_DBIT_NUM-1:0] data_q, data_d;
    logic                        line_q, line_d;
    logic                        done_q, done_d;

    logic                        w_idle;
    logic                        w_accept;
    logic                        w_hb_end;
    logic                        w_raw;
    logic                        w_raw_d;
    logic                        w_adc;
    logic                        w_bit_last;
    logic [BIT_W-1:0]            w_bit_num;
    logic [OWT_FSM_ST_W-1:0]     w_next_st;
    logic                        w_bit_val;
    logic                        w_crc_en;
    logic [OWT_CRC_BIT_NUM-1:0]  w_crc;
    logic [OWT_CRC_BIT_NUM-1:0]  w_crc_tx;
    logic [OWT_CMD_BIT_NUM-1:0]  w_cmd_sh;
    logic [OWT_ADC_DBIT_NUM-1:0] w_adc_sh;
    logic [OWT_DBIT_NUM-1:0]     w_nml_sh;
    logic [OWT_CRC_BIT_NUM-1:0]  w_crc_sh;
    logic [OWT_TAIL_BIT_NUM-1:0] w_tail_sh;

`ifdef HV_OWT_TX_CRC_ERR_INJ_EN
    logic inj_q, inj_d;
    assign w_crc_tx = w_crc ^ {OWT_CRC_BIT_NUM{inj_q}};
`else
    assign w_crc_tx = w_crc;
`endif

    assign w_idle     = (state_q == OWT_IDLE_ST);
    assign w_accept   = w_idle & i_owt_tx_req;
    assign w_hb_end   = !w_idle && (cyc_q == C_CYC_LAST);
    assign w_raw      = (state_q == OWT_SYNC_TAIL_ST) || (state_q == OWT_VLD_DATA_TAIL_ST);
    assign w_raw_d    = (state_d == OWT_SYNC_TAIL_ST) || (state_d == OWT_VLD_DATA_TAIL_ST);
    assign w_adc      = !cmd_q[OWT_CMD_BIT_NUM-1] && (cmd_q[6:0] == OWT_ADC_RD_CMD);
    assign w_bit_last = (bit_q == w_bit_num - 1'b1);

    // Raw tail states count half-bits in bit_q; Manchester states count bits.
    always_comb begin
        w_bit_num = BIT_W'(1);
        w_next_st = OWT_IDLE_ST;
        case (state_q)
            OWT_SYNC_HEAD_ST:     begin w_bit_num = BIT_W'(OWT_SYNC_BIT_NUM); w_next_st = OWT_SYNC_TAIL_ST;     end
            OWT_SYNC_TAIL_ST:     begin w_bit_num = BIT_W'(OWT_TAIL_BIT_NUM); w_next_st = OWT_CMD_ST;           end
            OWT_CMD_ST:           begin w_bit_num = BIT_W'(OWT_CMD_BIT_NUM);
                                        w_next_st = w_adc ? OWT_ADC_DATA_ST : OWT_NML_DATA_ST;                 end
            OWT_ADC_DATA_ST:      begin w_bit_num = BIT_W'(OWT_ADC_DBIT_NUM); w_next_st = OWT_CRC_ST;           end
            OWT_NML_DATA_ST:      begin w_bit_num = BIT_W'(OWT_DBIT_NUM);     w_next_st = OWT_CRC_ST;           end
            OWT_CRC_ST:           begin w_bit_num = BIT_W'(OWT_CRC_BIT_NUM);  w_next_st = OWT_VLD_DATA_TAIL_ST; end
            OWT_VLD_DATA_TAIL_ST: begin w_bit_num = BIT_W'(OWT_TAIL_BIT_NUM); w_next_st = OWT_IDLE_ST;          end
            default:              begin w_bit_num = BIT_W'(1);                w_next_st = OWT_IDLE_ST;          end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        half_d  = half_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef HV_OWT_TX_CRC_ERR_INJ_EN
        inj_d   = inj_q;
`endif
        if (w_accept) begin
            state_d = OWT_SYNC_HEAD_ST;
            cyc_d   = '0;
            bit_d   = '0;
            half_d  = 1'b0;
            cmd_d   = i_owt_tx_cmd;
            data_d  = i_owt_tx_data;
`ifdef HV_OWT_TX_CRC_ERR_INJ_EN
            inj_d   = i_owt_tx_crc_inj;
`endif
        end else if (!w_idle) begin
            if (!w_hb_end) begin
                cyc_d = cyc_q + 1'b1;
            end else begin
                cyc_d = '0;
                if (!w_raw && !half_q) begin
                    half_d = 1'b1;
                end else begin
                    half_d = 1'b0;
                    if (w_bit_last) begin
                        bit_d   = '0;
                        state_d = w_next_st;
                        done_d  = (state_q == OWT_VLD_DATA_TAIL_ST);
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
        end
    end

    // Line level and CRC input are derived from the upcoming half-bit so the line stays registered.
    assign w_cmd_sh  = cmd_q << bit_d;
    assign w_adc_sh  = data_q << bit_d;
    assign w_nml_sh  = data_q[OWT_DBIT_NUM-1:0] << bit_d;
    assign w_crc_sh  = w_crc_tx << bit_d;
    assign w_tail_sh = OWT_TAIL_PAT << bit_d;

    always_comb begin
        w_bit_val = 1'b0;
        case (state_d)
            OWT_CMD_ST:      w_bit_val = w_cmd_sh[OWT_CMD_BIT_NUM-1];
            OWT_ADC_DATA_ST: w_bit_val = w_adc_sh[OWT_ADC_DBIT_NUM-1];
            OWT_NML_DATA_ST: w_bit_val = w_nml_sh[OWT_DBIT_NUM-1];
            OWT_CRC_ST:      w_bit_val = w_crc_sh[OWT_CRC_BIT_NUM-1];
            default:         w_bit_val = 1'b0;
        endcase
        if (state_d == OWT_IDLE_ST) begin
            line_d = 1'b1;
        end else if (w_raw_d) begin
            line_d = w_tail_sh[OWT_TAIL_BIT_NUM-1];
        end else begin
            line_d = half_d ? w_bit_val : ~w_bit_val;
        end
    end

    assign w_crc_en = w_hb_end && !half_d &&
                      ((state_d == OWT_CMD_ST) || (state_d == OWT_ADC_DATA_ST) || (state_d == OWT_NML_DATA_ST));

    crc8_serial u_crc8_serial (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .clr_i  (w_accept),
        .en_i   (w_crc_en),
        .din_i  (w_bit_val),
        .crc_o  (w_crc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= OWT_IDLE_ST;
            cyc_q   <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            cmd_q   <= '0;
            data_q  <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

`ifdef HV_OWT_TX_CRC_ERR_INJ_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`endif

    assign o_owt_tx_ack   = w_accept;
    assign o_owt_tx_done  = done_q;
    assign o_owt_tx_busy  = !w_idle;
    assign o_hv_lv_owt_tx = line_q;

endmodule

`default_nettype wire
